// File: rtl/avmm_word_mem_if.sv
// Avalon-MM word bus between the word-copy master and the memory responder.
interface avmm_word_mem_if;
  logic [31:0] s_address;
  logic        s_read;
  logic [31:0] s_readdata;
  logic        s_readdatavalid;
  logic        s_write;
  logic [31:0] s_writedata;
  logic        s_waitrequest;
  logic        s_err;

  modport master (
    output s_address, s_read, s_write, s_writedata,
    input  s_readdata, s_readdatavalid, s_waitrequest, s_err
  );

  modport slave (
    input  s_address, s_read, s_write, s_writedata,
    output s_readdata, s_readdatavalid, s_waitrequest, s_err
  );
endinterface

// File: rtl/avmm_word_mem_responder.sv
// Avalon-MM word RAM with pipelined fixed-latency reads, forced stalls and an in-flight limit.
// Define AVMM_RESP_ERR_EN to enable address/command fault detection with a sticky s_err.
module avmm_word_mem_responder #(
  parameter int          DEPTH        = 1024,
  parameter logic [31:0] BASE_ADDR    = 32'h0,
  parameter int          READ_LATENCY = 2,
  parameter int          WAIT_CYCLES  = 0,
  parameter int          MAX_PENDING  = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  avmm_word_mem_if.slave  bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int SW = (WAIT_CYCLES < 1) ? 1 : $clog2(WAIT_CYCLES + 1);
  localparam int PW = $clog2(MAX_PENDING + 1);

  logic [31:0]   mem [DEPTH];
  logic          ready;
  logic [SW-1:0] stall_cnt;
  logic [PW-1:0] inflight;
  logic          waitreq;
  logic          accept;
  logic          is_read;
  logic          is_write;
  logic          fault;
  logic          wr_en;
  logic [AW-1:0] idx;
  logic [31:0]   rd_word;
  logic          resp_vld;
  logic [31:0]   resp_dat;
  logic          vld_out;
  logic [31:0]   rdata;

  // Only registered state feeds waitrequest, so it never combinationally follows the master.
  assign waitreq  = !ready || (stall_cnt != '0) || (inflight == PW'(MAX_PENDING));
  assign accept   = (bus.s_read || bus.s_write) && !waitreq;
  assign is_write = accept && bus.s_write;
  assign is_read  = accept && bus.s_read && !bus.s_write;
  assign idx      = AW'((bus.s_address - BASE_ADDR) >> 2);

`ifdef AVMM_RESP_ERR_EN
  localparam logic [32:0] LIMIT = {1'b0, BASE_ADDR} + 33'(4 * DEPTH);
  logic err;

  assign fault = (bus.s_address[1:0] != 2'b00) ||
                 ({1'b0, bus.s_address} < {1'b0, BASE_ADDR}) ||
                 ({1'b0, bus.s_address} >= LIMIT) ||
                 (bus.s_read && bus.s_write);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                err <= 1'b0;
    else if (accept && fault)  err <= 1'b1;
  end
  assign bus.s_err = err;
`else
  assign fault     = 1'b0;
  assign bus.s_err = 1'b0;
`endif

  assign wr_en   = is_write && !fault;
  assign rd_word = fault ? 32'hDEADBEEF : mem[idx];

  always_ff @(posedge clk) begin
    if (wr_en) mem[idx] <= bus.s_writedata;
  end

  // Stage p0..p(L-2): read data travels with its valid; the output register is the last stage.
  if (READ_LATENCY > 1) begin : g_pipe
    logic        vld_p [READ_LATENCY-1];
    logic [31:0] dat_p [READ_LATENCY-1];

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        for (int i = 0; i < READ_LATENCY - 1; i++) vld_p[i] <= 1'b0;
      end else begin
        vld_p[0] <= is_read;
        for (int i = 1; i < READ_LATENCY - 1; i++) vld_p[i] <= vld_p[i-1];
      end
    end

    always_ff @(posedge clk) begin
      dat_p[0] <= rd_word;
      for (int i = 1; i < READ_LATENCY - 1; i++) dat_p[i] <= dat_p[i-1];
    end

    assign resp_vld = vld_p[READ_LATENCY-2];
    assign resp_dat = dat_p[READ_LATENCY-2];
  end else begin : g_direct
    assign resp_vld = is_read;
    assign resp_dat = rd_word;
  end

  // A read leaves the in-flight count on the edge its response is loaded, freeing the slot
  // during the strobe cycle itself.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ready     <= 1'b0;
      stall_cnt <= '0;
      inflight  <= '0;
      vld_out   <= 1'b0;
      rdata     <= '0;
    end else begin
      ready   <= 1'b1;
      vld_out <= resp_vld;
      if (resp_vld) rdata <= resp_dat;

      if (accept)                 stall_cnt <= SW'(WAIT_CYCLES);
      else if (stall_cnt != '0)   stall_cnt <= stall_cnt - SW'(1);

      if (is_read && !resp_vld)        inflight <= inflight + PW'(1);
      else if (!is_read && resp_vld)   inflight <= inflight - PW'(1);
    end
  end

  assign bus.s_waitrequest   = waitreq;
  assign bus.s_readdatavalid = vld_out;
  assign bus.s_readdata      = rdata;
endmodule
